tft_char_ctrl: RTL

TFT_CHAR_CTRL -- requirements
Module: tft_char_ctrl

---
 rtl/tft_char_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tft_char_ctrl.sv
// tft_char_ctrl: bouncing character block controller for a TFT raster.
// Detects the last active pixel of each frame, emits a one-cycle frame_tick,
// and steps a CHAR_W x CHAR_H block around the active area, bouncing off the
// edges. Each bounce advances the colour and pauses the block for HOLD_FRAMES.
// Optional build macro: TFT_CHAR_BLINK_EN makes the block blink while paused.
module tft_char_ctrl #(
   parameter int H_VALID     = 480,
   parameter int V_VALID     = 272,
   parameter int CHAR_W      = 256,
   parameter int CHAR_H      = 64,
   parameter int INIT_H      = 112,
   parameter int INIT_V      = 104,
   parameter int STEP_FRAMES = 2,
   parameter int HOLD_FRAMES = 30
) (
   input  logic        tft_clk,
   input  logic        sys_rst_n,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        move_en,
   output logic [9:0]  char_b_h,
   output logic [9:0]  char_b_v,
   output logic [15:0] char_color,
   output logic        char_en,
   output logic        frame_tick
);

   localparam int H_MAX   = H_VALID - CHAR_W;
   localparam int V_MAX   = V_VALID - CHAR_H;
   localparam int CNT_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
   // at least 2 bits so the blink phase frame_cnt[1:0] always exists
   localparam int CNT_W   = (CNT_MAX > 4) ? $clog2(CNT_MAX) : 2;

   typedef enum logic [1:0] {WAIT, MOVE, HOLD} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] frame_cnt, cnt_nx;
   logic [9:0]       h_nx, v_nx, h_step, v_step;
   logic             dir_x, dir_y, dx_nx, dy_nx;
   logic             hit_x, hit_y;
   logic [1:0]       color_idx, cidx_nx;
   logic             at_last, last_d;
   logic             en_q, en_nx;

   assign at_last = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

   // rising-edge detect on the last active pixel -> single frame_tick pulse
   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         last_d     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         last_d     <= at_last;
         frame_tick <= at_last & ~last_d;
      end
   end

   // colour lookup, wraps naturally with the 2-bit index
   always_comb begin
      char_color = 16'hFEC0;
      case (color_idx)
         2'd0: char_color = 16'hFEC0;
         2'd1: char_color = 16'hF800;
         2'd2: char_color = 16'h07E0;
         2'd3: char_color = 16'h001F;
         default: char_color = 16'hFEC0;
      endcase
   end

   // candidate one-pixel step per axis, clamped so the block never leaves range
   always_comb begin
      h_step = char_b_h;
      v_step = char_b_v;
      if (dir_x && (char_b_h < 10'(H_MAX)))       h_step = char_b_h + 10'd1;
      else if (!dir_x && (char_b_h != 10'd0))     h_step = char_b_h - 10'd1;
      if (dir_y && (char_b_v < 10'(V_MAX)))       v_step = char_b_v + 10'd1;
      else if (!dir_y && (char_b_v != 10'd0))     v_step = char_b_v - 10'd1;
      hit_x = (h_step == 10'd0) || (h_step == 10'(H_MAX));
      hit_y = (v_step == 10'd0) || (v_step == 10'(V_MAX));
   end

   // next-state logic; everything only advances on a tick with move_en high
   always_comb begin
      state_nx = state;
      cnt_nx   = frame_cnt;
      h_nx     = char_b_h;
      v_nx     = char_b_v;
      dx_nx    = dir_x;
      dy_nx    = dir_y;
      cidx_nx  = color_idx;
      en_nx    = en_q;
      if (frame_tick && move_en) begin
         case (state)
            WAIT: state_nx = MOVE;
            MOVE: begin
               if (frame_cnt == CNT_W'(STEP_FRAMES - 1)) begin
                  cnt_nx = '0;
                  h_nx   = h_step;
                  v_nx   = v_step;
                  if (hit_x) dx_nx = ~dir_x;
                  if (hit_y) dy_nx = ~dir_y;
                  // a corner counts as one bounce: one colour advance
                  if (hit_x || hit_y) begin
                     cidx_nx  = color_idx + 2'd1;
                     state_nx = HOLD;
                  end
               end else begin
                  cnt_nx = frame_cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               if (frame_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                  cnt_nx   = '0;
                  state_nx = MOVE;
                  en_nx    = 1'b1;
               end else begin
                  cnt_nx = frame_cnt + CNT_W'(1);
`ifdef TFT_CHAR_BLINK_EN
                  if (frame_cnt[1:0] == 2'd3) en_nx = ~en_q;
`endif
               end
            end
            default: state_nx = WAIT;
         endcase
      end
   end

   // state, position, direction and colour registers
   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= WAIT;
         frame_cnt <= '0;
         char_b_h  <= 10'(INIT_H);
         char_b_v  <= 10'(INIT_V);
         dir_x     <= 1'b1;
         dir_y     <= 1'b1;
         color_idx <= 2'd0;
         en_q      <= 1'b1;
      end else begin
         state     <= state_nx;
         frame_cnt <= cnt_nx;
         char_b_h  <= h_nx;
         char_b_v  <= v_nx;
         dir_x     <= dx_nx;
         dir_y     <= dy_nx;
         color_idx <= cidx_nx;
         en_q      <= en_nx;
      end
   end

`ifdef TFT_CHAR_BLINK_EN
   assign char_en = en_q;
`else
   // en_q still tracks (always 1) but visibility is fixed in this build
   logic unused_en;
   assign unused_en = en_q;
   assign char_en   = 1'b1;
`endif

endmodule
